// File: rtl/im_pkg.sv
// Shared instruction-memory definitions: loader state encoding, memory
// geometry and the byte-address to word-index shift (also used for PC>>2).
package im_pkg;

    localparam int unsigned IM_DEPTH      = 256;
    localparam int unsigned IM_ADDR_SHIFT = 2;
    localparam int unsigned IM_WORD_W     = 32;
    localparam int unsigned IM_BYTE_W     = 8;
    localparam int unsigned IM_COUNT_W    = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR0 = 3'd1,
        HDR1 = 3'd2,
        DATA = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } im_state_e;

endpackage

// File: rtl/im_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the loader.
//   rx_valid/rx_data : byte source -> loader
//   rx_ready         : loader accepts a byte this cycle
//   im_we/im_addr/im_wdata : loader -> instruction memory write port
// slave  = loader side, master = host/memory side.
interface im_loader_if;
    import im_pkg::*;

    logic                 rx_valid;
    logic [IM_BYTE_W-1:0] rx_data;
    logic                 rx_ready;
    logic                 im_we;
    logic [IM_WORD_W-1:0] im_addr;
    logic [IM_WORD_W-1:0] im_wdata;

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, im_we, im_addr, im_wdata
    );

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, im_we, im_addr, im_wdata
    );

endinterface

// File: rtl/im_word_assembler.sv
// Big-endian byte-to-word assembler.
//   clk, rst_n     : clock, async active-low reset
//   clr            : synchronous clear of shift register and byte index
//   byte_valid     : accepted byte this cycle
//   byte_data      : the accepted byte
//   word_valid_c   : this byte completes a word (4th byte)
//   word_c         : completed word, valid with word_valid_c
module im_word_assembler
    import im_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 byte_valid,
    input  logic [IM_BYTE_W-1:0] byte_data,
    output logic                 word_valid_c,
    output logic [IM_WORD_W-1:0] word_c
);

    localparam int unsigned SHIFT_W = IM_WORD_W - IM_BYTE_W;

    logic [SHIFT_W-1:0] shift_q;
    logic [1:0]         byte_idx_q;

    // Only the three older bytes are stored; the 4th comes straight from the input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q    <= '0;
            byte_idx_q <= 2'd0;
        end else if (clr) begin
            shift_q    <= '0;
            byte_idx_q <= 2'd0;
        end else if (byte_valid) begin
            shift_q    <= {shift_q[SHIFT_W-IM_BYTE_W-1:0], byte_data};
            byte_idx_q <= byte_idx_q + 2'd1;
        end
    end

    assign word_valid_c = byte_valid && (byte_idx_q == 2'd3);
    assign word_c       = {shift_q, byte_data};

endmodule

// File: rtl/im_loader.sv
// Boot-time instruction memory loader: takes a 16-bit big-endian word count
// followed by big-endian 32-bit words, writes them sequentially from
// BASE_ADDR, and holds the CPU in reset until the image is in memory.
//   clk, rst_n : clock, async active-low reset
//   start      : one-cycle pulse, starts a load from IDLE/DONE/ERR
//   bus        : byte stream in, instruction memory write port out
//   cpu_hold   : CPU reset hold, released when a load completes
//   done       : level, last load completed
//   err        : level, header count exceeded DEPTH
module im_loader
    import im_pkg::*;
#(
    parameter int unsigned    DEPTH     = IM_DEPTH,
    parameter logic [31:0]    BASE_ADDR = 32'h0000_0000
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    im_loader_if.slave   bus,
    output logic         cpu_hold,
    output logic         done,
    output logic         err
);

    localparam int unsigned IDX_W = $clog2(DEPTH + 1);

    im_state_e             state_q;
    logic [IM_COUNT_W-1:0] count_q;
    logic [IDX_W-1:0]      idx_q;

    logic                  xfer_c;
    logic [IM_COUNT_W-1:0] hdr_count_c;
    logic [IDX_W-1:0]      idx_inc_c;
    logic                  word_valid_c;
    logic [IM_WORD_W-1:0]  word_c;

    assign bus.rx_ready = (state_q == HDR0) || (state_q == HDR1) || (state_q == DATA);
    assign xfer_c       = bus.rx_valid && bus.rx_ready;
    assign hdr_count_c  = {count_q[IM_COUNT_W-1:IM_BYTE_W], bus.rx_data};
    assign idx_inc_c    = idx_q + IDX_W'(1);

    // Byte assembly is only meaningful in DATA; any other state restarts it.
    im_word_assembler u_asm (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (state_q != DATA),
        .byte_valid   (xfer_c && (state_q == DATA)),
        .byte_data    (bus.rx_data),
        .word_valid_c (word_valid_c),
        .word_c       (word_c)
    );

    // Load sequencer with registered write port and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            idx_q        <= '0;
            bus.im_we    <= 1'b0;
            bus.im_addr  <= BASE_ADDR;
            bus.im_wdata <= '0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            bus.im_we <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= HDR0;
                    end
                end
                HDR0: begin
                    if (xfer_c) begin
                        count_q[IM_COUNT_W-1:IM_BYTE_W] <= bus.rx_data;
                        state_q <= HDR1;
                    end
                end
                HDR1: begin
                    if (xfer_c) begin
                        count_q[IM_BYTE_W-1:0] <= bus.rx_data;
                        idx_q                  <= '0;
                        if (32'(hdr_count_c) > 32'(DEPTH)) begin
                            state_q <= ERR;
                            err     <= 1'b1;
                        end else if (hdr_count_c == '0) begin
                            state_q  <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (word_valid_c) begin
                        bus.im_we    <= 1'b1;
                        bus.im_addr  <= BASE_ADDR + (32'(idx_q) << IM_ADDR_SHIFT);
                        bus.im_wdata <= word_c;
                        idx_q        <= idx_inc_c;
                        // Release the CPU together with the last write pulse.
                        if (32'(idx_inc_c) == 32'(count_q)) begin
                            state_q  <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end
                    end
                end
                DONE, ERR: begin
                    if (start) begin
                        state_q  <= HDR0;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        cpu_hold <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: directed scenarios plus random images,
// checked against an image-level model of the expected memory writes.
module tb_im_loader;

    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
        logic        done;
        logic        hold;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic cpu_hold, done, err;

    im_loader_if bus();

    im_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    int  last_acc;
    wr_t obs_q[$];
    wr_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Every cycle with im_we high is one memory write.
    always @(negedge clk) begin
        if (bus.im_we === 1'b1) begin
            wr_t w;
            w.addr = bus.im_addr;
            w.data = bus.im_wdata;
            w.cyc  = cyc;
            w.done = done;
            w.hold = cpu_hold;
            obs_q.push_back(w);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".rx_ready"}, 64'(bus.rx_ready), 64'(0));
        chk({tag, ".im_we"},    64'(bus.im_we),    64'(0));
        chk({tag, ".im_addr"},  64'(bus.im_addr),  64'(BASE));
        chk({tag, ".im_wdata"}, 64'(bus.im_wdata), 64'(0));
        chk({tag, ".cpu_hold"}, 64'(cpu_hold),     64'(1));
        chk({tag, ".done"},     64'(done),         64'(0));
        chk({tag, ".err"},      64'(err),          64'(0));
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Offer one byte after 'gap' idle cycles; returns #1 after its acceptance edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        while (bus.rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("byte_accepted", 64'(bus.rx_ready), 64'(1));
        last_acc = cyc + 1;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    function automatic byte_q_t make_img(input int cnt);
        byte_q_t q;
        q.push_back(8'(cnt >> 8));
        q.push_back(8'(cnt));
        for (int i = 0; i < 4 * cnt; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic check_writes(input string tag);
        int n;
        chk({tag, ".nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, ".addr"},  64'(obs_q[i].addr), 64'(exp_q[i].addr));
            chk({tag, ".data"},  64'(obs_q[i].data), 64'(exp_q[i].data));
            chk({tag, ".lat"},   64'(obs_q[i].cyc),  64'(exp_q[i].cyc));
            chk({tag, ".wdone"}, 64'(obs_q[i].done), 64'(exp_q[i].done));
            chk({tag, ".whold"}, 64'(obs_q[i].hold), 64'(exp_q[i].hold));
        end
    endtask

    // Full load: start, stream the image with gaps in [gmin,gmax], compare
    // writes and final status. mid >= 0 raises start alongside that byte.
    task automatic run_load(input string tag, input byte_q_t img,
                            input int gmin, input int gmax, input int mid);
        int  cnt, w;
        bit  ok;
        wr_t e;
        obs_q.delete();
        exp_q.delete();
        pulse_start();
        chk({tag, ".start_done"}, 64'(done),         64'(0));
        chk({tag, ".start_err"},  64'(err),          64'(0));
        chk({tag, ".start_hold"}, 64'(cpu_hold),     64'(1));
        chk({tag, ".start_rdy"},  64'(bus.rx_ready), 64'(1));
        cnt = int'({img[0], img[1]});
        ok  = (cnt <= int'(DEPTH));
        for (int i = 0; i < img.size(); i++) begin
            if (i == mid) start = 1'b1;
            send_byte(img[i], int'($urandom_range(gmax, gmin)));
            start = 1'b0;
            if (i >= 5 && ((i - 2) % 4) == 3) begin
                w      = (i - 2) / 4;
                e.addr = BASE + 32'(w * 4);
                e.data = {img[i-3], img[i-2], img[i-1], img[i]};
                e.cyc  = last_acc;
                e.done = (w == cnt - 1);
                e.hold = !(w == cnt - 1);
                exp_q.push_back(e);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        check_writes(tag);
        chk({tag, ".done"},     64'(done),         64'(ok));
        chk({tag, ".err"},      64'(err),          64'(!ok));
        chk({tag, ".cpu_hold"}, 64'(cpu_hold),     64'(!ok));
        chk({tag, ".rx_ready"}, 64'(bus.rx_ready), 64'(0));
        chk({tag, ".im_we"},    64'(bus.im_we),    64'(0));
    endtask

    initial begin
        byte_q_t img;
        rst_n        = 1'b0;
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        #12;
        check_reset("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle.hold", 64'(cpu_hold), 64'(1));

        // Two-word image at full rate, then with valid every other cycle.
        img = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
        run_load("t1", img, 0, 0, -1);
        run_load("t2", img, 1, 1, -1);

        // Empty image.
        img = '{8'h00, 8'h00};
        run_load("t3", img, 0, 0, -1);

        // Oversized count, then recovery with one word.
        img = '{8'h01, 8'h01};
        run_load("t4err", img, 0, 0, -1);
        img = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_load("t4ok", img, 0, 0, -1);

        // Reset after the first word of a two-word load.
        img = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        obs_q.delete();
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(img[i], 0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_reset("t5rst");
        chk("t5.nwrites", 64'(obs_q.size()), 64'(1));
        if (obs_q.size() > 0) begin
            chk("t5.addr", 64'(obs_q[0].addr), 64'(BASE));
            chk("t5.data", 64'(obs_q[0].data), 64'(32'h11223344));
        end
        @(posedge clk); #1 rst_n = 1'b1;
        run_load("t5reload", img, 0, 0, -1);

        // Start during DATA is ignored; reload from DONE to the same addresses.
        run_load("t6mid", make_img(3), 0, 1, 5);
        run_load("t6again", make_img(3), 0, 0, -1);

        // Random images and pacing.
        for (int r = 0; r < 6; r++) begin
            run_load("rand", make_img(int'($urandom_range(8, 1))), 0, 2, -1);
        end

        // Exactly DEPTH words is accepted.
        run_load("full", make_img(int'(DEPTH)), 0, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
